// File: rtl/rv_pkg.sv
// Shared RV64 datapath constants: default data width, major opcodes and
// the instruction field positions decode uses to drive register addresses.
package rv_pkg;

  localparam int XLEN_DEFAULT = 64;
  localparam int REG_FIELD_W  = 5;

  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam int RS1_LSB = 15;
  localparam int RS2_LSB = 20;
  localparam int RD_LSB  = 7;

  function automatic logic [REG_FIELD_W-1:0] rs1_of(input logic [31:0] instr);
    return instr[RS1_LSB +: REG_FIELD_W];
  endfunction

  function automatic logic [REG_FIELD_W-1:0] rs2_of(input logic [31:0] instr);
    return instr[RS2_LSB +: REG_FIELD_W];
  endfunction

  function automatic logic [REG_FIELD_W-1:0] rd_of(input logic [31:0] instr);
    return instr[RD_LSB +: REG_FIELD_W];
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set at issue and
// cleared at writeback, with a registered popcount and per-port busy flags.
module rf_scoreboard #(
  parameter  int NREGS  = 32,
  parameter  int NRD    = 2,
  parameter  int BYPASS = 1,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NRD*AW-1:0] rd_addr,
  input  logic              reg_write,
  input  logic [AW-1:0]     wr_addr,
  input  logic              issue_en,
  input  logic [AW-1:0]     issue_rd,
  output logic [NRD-1:0]    rd_busy,
  output logic [AW:0]       pending_cnt,
  output logic [NREGS-1:0]  busy_vec
);

  logic [NREGS-1:0] busy_q, busy_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic [AW-1:0]    port_addr;

  // Issue is applied after writeback so a new producer wins over a retiring one.
  always_comb begin
    busy_d = busy_q;
    if (reg_write && wr_addr != '0) busy_d[wr_addr] = 1'b0;
    if (issue_en && issue_rd != '0) busy_d[issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
    cnt_d = '0;
    for (int r = 0; r < NREGS; r++) begin
      cnt_d = cnt_d + {{AW{1'b0}}, busy_d[r]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    rd_busy   = '0;
    port_addr = '0;
    for (int i = 0; i < NRD; i++) begin
      port_addr  = rd_addr[i*AW +: AW];
      rd_busy[i] = (port_addr != '0) && busy_q[port_addr] &&
                   !((BYPASS != 0) && reg_write && (wr_addr == port_addr));
    end
  end

  assign busy_vec    = busy_q;
  assign pending_cnt = cnt_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// Integer register file with NRD combinational read ports, one write port,
// hardwired x0, optional write-to-read bypass and a pending-write scoreboard.
module regfile_scoreboard
  import rv_pkg::*;
#(
  parameter  int XLEN   = XLEN_DEFAULT,
  parameter  int NREGS  = 32,
  parameter  int NRD    = 2,
  parameter  int BYPASS = 1,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic                reg_write,
  input  logic [AW-1:0]       wr_addr,
  input  logic [XLEN-1:0]     write_data,
  input  logic                issue_en,
  input  logic [AW-1:0]       issue_rd,
  output logic [AW:0]         pending_cnt,
  output logic [NREGS-1:0]    busy_vec
);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [AW-1:0]   port_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) regs_q[r] <= '0;
    end else if (reg_write && wr_addr != '0) begin
      regs_q[wr_addr] <= write_data;
    end
  end

  // Reads are forced to zero while in reset so a forwarded write cannot leak out.
  always_comb begin
    rd_data   = '0;
    port_addr = '0;
    for (int i = 0; i < NRD; i++) begin
      port_addr = rd_addr[i*AW +: AW];
      if (!rst_n || port_addr == '0)
        rd_data[i*XLEN +: XLEN] = '0;
      else if ((BYPASS != 0) && reg_write && (wr_addr == port_addr))
        rd_data[i*XLEN +: XLEN] = write_data;
      else
        rd_data[i*XLEN +: XLEN] = regs_q[port_addr];
    end
  end

  rf_scoreboard #(
    .NREGS  (NREGS),
    .NRD    (NRD),
    .BYPASS (BYPASS)
  ) u_scoreboard (
    .clk         (clk),
    .rst_n       (rst_n),
    .rd_addr     (rd_addr),
    .reg_write   (reg_write),
    .wr_addr     (wr_addr),
    .issue_en    (issue_en),
    .issue_rd    (issue_rd),
    .rd_busy     (rd_busy),
    .pending_cnt (pending_cnt),
    .busy_vec    (busy_vec)
  );

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Drives a bypassing and a non-bypassing register file with identical stimulus
// and compares both against an array-based architectural model.
module tb_regfile_scoreboard;

  localparam int XLEN  = 64;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int AW    = 5;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NRD*AW-1:0]   rd_addr;
  logic                reg_write;
  logic [AW-1:0]       wr_addr;
  logic [XLEN-1:0]     write_data;
  logic                issue_en;
  logic [AW-1:0]       issue_rd;

  logic [NRD*XLEN-1:0] bData, nData;
  logic [NRD-1:0]      bBusy, nBusy;
  logic [AW:0]         bCnt, nCnt;
  logic [NREGS-1:0]    bVec, nVec;

  int nChecks = 0;
  int nFails  = 0;

  logic [XLEN-1:0] mRegs [NREGS];
  bit              mBusy [NREGS];

  regfile_scoreboard #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS(1)) dutByp (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(bData), .rd_busy(bBusy),
    .reg_write(reg_write), .wr_addr(wr_addr), .write_data(write_data),
    .issue_en(issue_en), .issue_rd(issue_rd), .pending_cnt(bCnt), .busy_vec(bVec)
  );

  regfile_scoreboard #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS(0)) dutNoByp (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(nData), .rd_busy(nBusy),
    .reg_write(reg_write), .wr_addr(wr_addr), .write_data(write_data),
    .issue_en(issue_en), .issue_rd(issue_rd), .pending_cnt(nCnt), .busy_vec(nVec)
  );

  always #5 clk = ~clk;

  // Reference model: what a read should return given stored state and this cycle's inputs.
  function automatic logic [XLEN-1:0] expData(input bit byp, input logic [AW-1:0] a);
    if (!rst_n || a == 0) return '0;
    if (byp && reg_write && wr_addr == a) return write_data;
    return mRegs[a];
  endfunction

  function automatic logic expRdBusy(input bit byp, input logic [AW-1:0] a);
    if (!rst_n || a == 0) return 1'b0;
    return mBusy[a] && !(byp && reg_write && wr_addr == a);
  endfunction

  function automatic int expCnt();
    int n = 0;
    for (int r = 0; r < NREGS; r++) n += int'(mBusy[r]);
    return n;
  endfunction

  function automatic logic [NREGS-1:0] expVec();
    logic [NREGS-1:0] v = '0;
    for (int r = 0; r < NREGS; r++) v[r] = mBusy[r];
    return v;
  endfunction

  task automatic modelReset();
    for (int r = 0; r < NREGS; r++) begin
      mRegs[r] = '0;
      mBusy[r] = 1'b0;
    end
  endtask

  task automatic modelEdge();
    if (rst_n) begin
      if (reg_write && wr_addr != 0) begin
        mRegs[wr_addr] = write_data;
        mBusy[wr_addr] = 1'b0;
      end
      if (issue_en && issue_rd != 0) mBusy[issue_rd] = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    modelEdge();
    #2;
  endtask

  task automatic drive(input logic re, input logic [AW-1:0] wa, input logic [XLEN-1:0] wd,
                       input logic ie, input logic [AW-1:0] ir,
                       input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    reg_write  = re;
    wr_addr    = wa;
    write_data = wd;
    issue_en   = ie;
    issue_rd   = ir;
    rd_addr    = {a1, a0};
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    modelReset();
    drive(0, 0, 0, 0, 0, 5, 5);
    nChecks++; if (bCnt !== 6'd0) begin nFails++; $display("[TB] FAIL reset_cnt got %0d want 0", bCnt); end
    nChecks++; if (bVec !== 32'h0) begin nFails++; $display("[TB] FAIL reset_vec got %h want 0", bVec); end
    nChecks++; if (bData !== 128'h0) begin nFails++; $display("[TB] FAIL reset_data got %h want 0", bData); end
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 5, 64'hDEAD, 1, 6, 5, 5);
    tick();
    drive(0, 0, 0, 0, 0, 5, 6);
    nChecks++; if (bData[63:0] !== 64'hDEAD) begin nFails++; $display("[TB] FAIL pre_reset_x5 got %h want dead", bData[63:0]); end
    nChecks++; if (bCnt !== 6'd1) begin nFails++; $display("[TB] FAIL pre_reset_cnt got %0d want 1", bCnt); end
    drive(1, 5, 64'hBEEF, 1, 5, 5, 5);
    rst_n = 1'b0;
    modelReset();
    #1;
    nChecks++; if (bData !== 128'h0) begin nFails++; $display("[TB] FAIL midreset_data_byp got %h want 0", bData); end
    nChecks++; if (nData !== 128'h0) begin nFails++; $display("[TB] FAIL midreset_data_nobyp got %h want 0", nData); end
    nChecks++; if (bVec !== 32'h0 || nVec !== 32'h0) begin nFails++; $display("[TB] FAIL midreset_vec got %h/%h want 0", bVec, nVec); end
    nChecks++; if (bCnt !== 6'd0 || nCnt !== 6'd0) begin nFails++; $display("[TB] FAIL midreset_cnt got %0d/%0d want 0", bCnt, nCnt); end
    nChecks++; if (bBusy !== 2'b00) begin nFails++; $display("[TB] FAIL midreset_rdbusy got %b want 00", bBusy); end
    tick();
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 5, 6);
    nChecks++; if (bData !== 128'h0) begin nFails++; $display("[TB] FAIL reset_lost_write got %h want 0", bData); end
    drive(1, 5, 64'h77, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 5, 5);
    nChecks++; if (nData !== {2{64'h77}}) begin nFails++; $display("[TB] FAIL first_edge_write got %h want 77 on both", nData); end
  endtask

  task automatic test_x0();
    drive(1, 0, '1, 1, 0, 0, 0);
    nChecks++; if (bData !== 128'h0 || nData !== 128'h0) begin nFails++; $display("[TB] FAIL x0_bypass got %h/%h want 0", bData, nData); end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    nChecks++; if (bVec[0] !== 1'b0) begin nFails++; $display("[TB] FAIL x0_busy got %b want 0", bVec[0]); end
    nChecks++; if (bCnt !== 6'(expCnt())) begin nFails++; $display("[TB] FAIL x0_cnt got %0d want %0d", bCnt, expCnt()); end
    nChecks++; if (bData !== 128'h0) begin nFails++; $display("[TB] FAIL x0_read got %h want 0", bData); end
  endtask

  task automatic test_bypass();
    drive(1, 7, 64'h11, 0, 0, 0, 0);
    tick();
    drive(1, 7, 64'h22, 0, 0, 7, 7);
    nChecks++; if (bData !== {2{64'h22}}) begin nFails++; $display("[TB] FAIL bypass_same_cycle got %h want 22 on both", bData); end
    nChecks++; if (nData !== {2{64'h11}}) begin nFails++; $display("[TB] FAIL nobypass_same_cycle got %h want 11 on both", nData); end
    tick();
    drive(0, 0, 0, 0, 0, 7, 7);
    nChecks++; if (bData !== {2{64'h22}}) begin nFails++; $display("[TB] FAIL bypass_next_cycle got %h want 22", bData); end
    nChecks++; if (nData !== {2{64'h22}}) begin nFails++; $display("[TB] FAIL nobypass_next_cycle got %h want 22", nData); end
  endtask

  task automatic test_scoreboard();
    drive(0, 0, 0, 1, 3, 3, 3);
    tick();
    drive(0, 0, 0, 0, 0, 3, 3);
    nChecks++; if (bBusy !== 2'b11 || nBusy !== 2'b11) begin nFails++; $display("[TB] FAIL sb_issue_busy got %b/%b want 11", bBusy, nBusy); end
    nChecks++; if (bCnt !== 6'd1) begin nFails++; $display("[TB] FAIL sb_issue_cnt got %0d want 1", bCnt); end
    drive(1, 3, 64'h5, 0, 0, 3, 3);
    nChecks++; if (bBusy !== 2'b00) begin nFails++; $display("[TB] FAIL sb_wb_busy_byp got %b want 00", bBusy); end
    nChecks++; if (bData !== {2{64'h5}}) begin nFails++; $display("[TB] FAIL sb_wb_data_byp got %h want 5", bData); end
    nChecks++; if (nBusy !== 2'b11) begin nFails++; $display("[TB] FAIL sb_wb_busy_nobyp got %b want 11", nBusy); end
    nChecks++; if (bCnt !== 6'd1) begin nFails++; $display("[TB] FAIL sb_wb_cnt_same_cycle got %0d want 1", bCnt); end
    tick();
    drive(0, 0, 0, 0, 0, 3, 3);
    nChecks++; if (bCnt !== 6'd0 || nCnt !== 6'd0) begin nFails++; $display("[TB] FAIL sb_retired_cnt got %0d/%0d want 0", bCnt, nCnt); end
    nChecks++; if (nBusy !== 2'b00) begin nFails++; $display("[TB] FAIL sb_retired_busy_nobyp got %b want 00", nBusy); end
    nChecks++; if (nData !== {2{64'h5}}) begin nFails++; $display("[TB] FAIL sb_retired_data got %h want 5", nData); end
  endtask

  task automatic test_collision();
    drive(0, 0, 0, 1, 9, 0, 0);
    tick();
    drive(1, 9, 64'hABC, 1, 9, 9, 9);
    tick();
    drive(0, 0, 0, 0, 0, 9, 9);
    nChecks++; if (bBusy !== 2'b11 || nBusy !== 2'b11) begin nFails++; $display("[TB] FAIL collide_busy got %b/%b want 11", bBusy, nBusy); end
    nChecks++; if (bCnt !== 6'd1) begin nFails++; $display("[TB] FAIL collide_cnt got %0d want 1", bCnt); end
    nChecks++; if (bVec !== 32'h0000_0200) begin nFails++; $display("[TB] FAIL collide_vec got %h want 00000200", bVec); end
    nChecks++; if (bData !== {2{64'hABC}}) begin nFails++; $display("[TB] FAIL collide_data got %h want abc", bData); end
    drive(1, 9, 64'hABC, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_fill_random();
    logic [AW-1:0] a;
    for (int r = 1; r < NREGS; r++) begin
      drive(0, 0, 0, 1, 5'(r), 5'($urandom), 5'($urandom));
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    nChecks++; if (bCnt !== 6'd31 || nCnt !== 6'd31) begin nFails++; $display("[TB] FAIL fill_cnt got %0d/%0d want 31", bCnt, nCnt); end
    nChecks++; if (bVec !== 32'hFFFF_FFFE) begin nFails++; $display("[TB] FAIL fill_vec got %h want fffffffe", bVec); end
    for (int step = 0; step < 331; step++) begin
      if (step < NREGS - 1)
        drive(1, 5'(step + 1), {$urandom, $urandom}, 0, 0, 5'($urandom), 5'($urandom));
      else
        drive($urandom_range(0, 1) == 1, 5'($urandom), {$urandom, $urandom},
              $urandom_range(0, 1) == 1, 5'($urandom),
              ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom), 5'($urandom));
      for (int i = 0; i < NRD; i++) begin
        a = rd_addr[i*AW +: AW];
        nChecks++; if (bData[i*XLEN +: XLEN] !== expData(1, a)) begin nFails++; $display("[TB] FAIL rand_data_byp step %0d port %0d addr %0d got %h want %h", step, i, a, bData[i*XLEN +: XLEN], expData(1, a)); end
        nChecks++; if (nData[i*XLEN +: XLEN] !== expData(0, a)) begin nFails++; $display("[TB] FAIL rand_data_nobyp step %0d port %0d addr %0d got %h want %h", step, i, a, nData[i*XLEN +: XLEN], expData(0, a)); end
        nChecks++; if (bBusy[i] !== expRdBusy(1, a)) begin nFails++; $display("[TB] FAIL rand_busy_byp step %0d port %0d addr %0d got %b want %b", step, i, a, bBusy[i], expRdBusy(1, a)); end
        nChecks++; if (nBusy[i] !== expRdBusy(0, a)) begin nFails++; $display("[TB] FAIL rand_busy_nobyp step %0d port %0d addr %0d got %b want %b", step, i, a, nBusy[i], expRdBusy(0, a)); end
      end
      tick();
      #1;
      nChecks++; if (bCnt !== 6'(expCnt()) || nCnt !== 6'(expCnt())) begin nFails++; $display("[TB] FAIL rand_cnt step %0d got %0d/%0d want %0d", step, bCnt, nCnt, expCnt()); end
      nChecks++; if (bVec !== expVec() || nVec !== expVec()) begin nFails++; $display("[TB] FAIL rand_vec step %0d got %h/%h want %h", step, bVec, nVec, expVec()); end
      if (step == NREGS - 2) begin
        nChecks++; if (bCnt !== 6'd0) begin nFails++; $display("[TB] FAIL retire_all_cnt got %0d want 0", bCnt); end
      end
    end
  endtask

  initial begin
    $display("[TB] regfile_scoreboard bench start");
    test_reset();
    test_x0();
    test_bypass();
    test_scoreboard();
    test_collision();
    test_fill_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
